muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit for the five-stage core. It accepts one M-extension operation from the execute stage and runs it over multiple cycles. It holds `busy` high for the duration, and that signal is what the hazard unit turns into fetch/decode stalls for an M-class instruction. It delivers the result with a one-cycle `done` pulse, after which the pipeline resumes and the result is written back.

## Interface
- `XLEN`, 32, operand/result width; the iteration count equals `XLEN`.

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand.
- `b`  in  XLEN  rs2 operand.
- `flush`  in  1  abort current operation (branch/jump redirect).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  high for exactly one cycle while in DONE; `result` is valid in that cycle.
- `result`  out  XLEN  registered result; held until the next accepted `start`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- On the IDLE edge with `start=1`:
  - Latch `op`, `a`, `b`. Input changes after acceptance are ignored.
  - Compute operand magnitudes and the result sign.
  - MUL/MULH/MULHSU/MULHU go to MUL.
  - DIV/DIVU/REM/REMU go to DIV, except the special cases below, which go directly to DONE.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
- MUL state: shift-add, one multiplier bit per cycle, 2·XLEN-bit unsigned accumulator, `XLEN` cycles.
  - At the end, negate the product if the result sign is negative.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DIV state: restoring division, one quotient bit per cycle, `XLEN` cycles, unsigned magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases, resolved at acceptance. Result is loaded immediately and the next state is DONE.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return `a`.
  - Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE: `done=1`, `busy=1`; next state is IDLE unconditionally.
- `start` in any non-IDLE state is ignored. No queueing.
- `flush`:
  - In any state, next state is IDLE and no `done` pulse occurs.
  - `flush` has priority over `start` in the same cycle.
  - `result` is not updated by an aborted operation.
- `done` and the IDLE acceptance cannot coincide. A new `start` is accepted at the earliest on the edge that leaves DONE + 1 cycle, i.e. in the following IDLE cycle.

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - state=IDLE, `busy=0`, `done=0`, `result=0`.
  - Internal accumulators and the counter are cleared.
- Let E0 be the accepting edge. `busy` rises after E0.
- Normal operation:
  - Iterations occur on edges E1..E`XLEN`.
  - DONE is entered at E`XLEN`, so `done` is high during the cycle after E32 (XLEN=32).
  - IDLE is entered at E33. Total latency is 33 cycles; throughput is one operation per 34 cycles.
- Special cases: `done` is high in the cycle after E0, and `busy` falls after E1.
- `busy` and `done` are decoded from state registers only. No combinational path runs from inputs to outputs.
- The iteration counter is a ceil(log2(XLEN))+1-bit counter. It is reset on acceptance and compared to `XLEN`-1; no wrap.
- Reset asserted mid-operation drops `busy`/`done` asynchronously. After release, the unit is in IDLE and accepts `start` on the first edge.

## Test plan
- MUL `a`=7, `b`=0xFFFFFFFD -> `result`=0xFFFFFFEB. `done` is high exactly 32 edges after E0; `busy` is high for 33 cycles.
- Multiply high halves, one operation each:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Division signs:
  - DIV −7/2 -> 0xFFFFFFFD.
  - REM −7%2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100%7 -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5%0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
  - Each has `done` in the cycle after E0.
- Start DIVU 100/7, assert `flush` on E10:
  - `busy`=0 after E10, no `done`, `result` unchanged.
  - Then MUL 3×4 -> 12 with normal latency.
  - A `start` pulsed mid-operation with changed `a`/`b` does not alter the result or restart the unit.
- Assert `rst_n`=0 asynchronously at iteration 15:
  - `busy`, `done`, and `result` go to 0 immediately.
  - After release, DIV 9/3 -> 3 with 33-cycle latency.

Source files
------------

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : Request/response bundle between execute stage and muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit (shift-add / restoring div).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    muldiv_unit_if.slave bus
);

    localparam int              c_CNT_W    = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [XLEN-1:0] c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_result;
    logic [2:0]         r_op;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_mcand;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;

    // ------------------------------------------------------------------
    // Acceptance-time decode: signedness, magnitudes, special cases
    // ------------------------------------------------------------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;

    assign w_a_signed = (bus.op == c_OP_MUL) || (bus.op == c_OP_MULH) ||
                        (bus.op == c_OP_MULHSU) || (bus.op == c_OP_DIV) ||
                        (bus.op == c_OP_REM);
    assign w_b_signed = (bus.op == c_OP_MUL) || (bus.op == c_OP_MULH) ||
                        (bus.op == c_OP_DIV) || (bus.op == c_OP_REM);
    assign w_a_neg    = w_a_signed & bus.a[XLEN-1];
    assign w_b_neg    = w_b_signed & bus.b[XLEN-1];
    assign w_a_mag    = w_a_neg ? ('0 - bus.a) : bus.a;
    assign w_b_mag    = w_b_neg ? ('0 - bus.b) : bus.b;

    assign w_div0     = (bus.b == '0);
    assign w_ovf      = ((bus.op == c_OP_DIV) || (bus.op == c_OP_REM)) &&
                        (bus.a == c_INT_MIN) && (bus.b == '1);

    // op[1] separates quotient-type (DIV/DIVU) from remainder-type (REM/REMU)
    always_comb begin
        w_special = '0;
        if (w_div0) begin
            w_special = bus.op[1] ? bus.a : '1;
        end else if (w_ovf) begin
            w_special = bus.op[1] ? '0 : c_INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Multiply step: upper half accumulates, whole register shifts right
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_mul_res;

    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod_s   = r_neg_q ? ('0 - w_mul_next) : w_mul_next;
    assign w_mul_res  = (r_op == c_OP_MUL) ? w_prod_s[XLEN-1:0]
                                           : w_prod_s[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // Restoring divide step: r_acc = {partial remainder, dividend/quotient}
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_div_res;

    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
    assign w_div_next  = w_div_diff[XLEN]
                       ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                       : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
    assign w_quo       = w_div_next[XLEN-1:0];
    assign w_rem       = w_div_next[2*XLEN-1:XLEN];
    assign w_div_res   = r_op[1] ? (r_neg_r ? ('0 - w_rem) : w_rem)
                                 : (r_neg_q ? ('0 - w_quo) : w_quo);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_cnt   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_busy  <= 1'b1;
                        if (!bus.op[2]) begin
                            r_acc   <= {{XLEN{1'b0}}, w_b_mag};
                            r_mcand <= w_a_mag;
                            r_state <= S_MUL;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                            r_mcand <= w_b_mag;
                            if (w_div0 || w_ovf) begin
                                r_result <= w_special;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_state <= S_DIV;
                            end
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result <= w_mul_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result <= w_div_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed scoreboard bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam logic [2:0] c_MUL    = 3'b000;
    localparam logic [2:0] c_MULH   = 3'b001;
    localparam logic [2:0] c_MULHSU = 3'b010;
    localparam logic [2:0] c_MULHU  = 3'b011;
    localparam logic [2:0] c_DIV    = 3'b100;
    localparam logic [2:0] c_DIVU   = 3'b101;
    localparam logic [2:0] c_REM    = 3'b110;
    localparam logic [2:0] c_REMU   = 3'b111;

    logic clk;
    logic rst_n;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] last_result;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit spurious);
        int          n;
        int          busy_cycles;
        logic [31:0] want;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        sb.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({name, "_busy_after_E0"}, 32'(bus.busy), 32'd1);
        n = 0;
        busy_cycles = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk); #1;
            n++;
            if (spurious && n == 5) begin
                bus.start = 1'b1;
                bus.a     = 32'd99;
                bus.b     = 32'd99;
            end else if (spurious && n == 6) begin
                bus.start = 1'b0;
            end
        end
        if (bus.busy) busy_cycles++;
        check({name, "_latency"}, 32'(n), 32'(lat));
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(lat + 1));
        if (bus.done && sb.size() != 0) begin
            want = sb.pop_front();
            check({name, "_result"}, bus.result, want);
            last_result = want;
        end else begin
            check({name, "_done_seen"}, 32'(bus.done), 32'd1);
            sb.delete();
        end
        @(posedge clk); #1;
        check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({name, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int done_seen;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        last_result = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Multiply
        run_op("mul",    c_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, 1'b0);
        run_op("mulh",   c_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32, 1'b0);
        run_op("mulhu",  c_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 1'b0);
        run_op("mulhsu", c_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 1'b0);

        // Divide signs
        run_op("div",  c_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, 1'b0);
        run_op("rem",  c_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, 1'b0);
        run_op("divu", c_DIVU, 32'd100,      32'd7, 32'd14,       32, 1'b0);
        run_op("remu", c_REMU, 32'd100,      32'd7, 32'd2,        32, 1'b0);

        // Special cases resolve at acceptance
        run_op("div0",   c_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1'b0);
        run_op("rem0",   c_REM, 32'd5,        32'd0,        32'd5,        0, 1'b0);
        run_op("divovf", c_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0);
        run_op("removf", c_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1'b0);

        // Flush at E10 of a DIVU
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = c_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_result_held", bus.result, last_result);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        check("flush_no_done", 32'(done_seen), 32'd0);

        // Normal op after flush, with an ignored mid-operation start
        run_op("mul_after_flush", c_MUL, 32'd3, 32'd4, 32'd12, 32, 1'b1);

        // Asynchronous reset at iteration 15
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = c_MUL;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        check("async_rst_result", bus.result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        last_result = '0;

        run_op("div_after_rst", c_DIV, 32'd9, 32'd3, 32'd3, 32, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
